// File: rtl/tx_stream_pkg.sv
// tx_stream_pkg: shared FSM state type and address-width helper for tx_stream.
package tx_stream_pkg;

    typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, DONE} tx_state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_stream_fsm.sv
// tx_stream_fsm: frame sequencing state machine and its output decode.
module tx_stream_fsm
    import tx_stream_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_last_bit,
    input  logic i_last_word,
    output logic o_clr,
    output logic o_load,
    output logic o_mem_rd,
    output logic o_tx_valid,
    output logic o_tx_finish,
    output logic o_busy
);

    tx_state_t r_state, w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_clr       = 1'b0;
        o_load      = r_state == LOAD;
        o_mem_rd    = r_state == READ;
        o_tx_valid  = r_state == SEND;
        o_tx_finish = r_state == DONE;
        o_busy      = r_state != IDLE;
        unique case (r_state)
            IDLE: begin
                o_clr = i_start;
                if (i_start) w_next = READ;
            end
            READ: w_next = LOAD;
            LOAD: w_next = SEND;
            SEND: if (i_last_bit) w_next = i_last_word ? DONE : READ;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: rtl/tx_stream.sv
// tx_stream: streams NUM_WORDS memory words as a valid/ready serial bit stream.
// Define TX_STREAM_PARITY_EN to append an even-parity bit after each word.
module tx_stream
    import tx_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic                             i_rx_ready,
    output logic                             o_mem_rd,
    output logic [addr_width(NUM_WORDS)-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]            i_mem_q,
    output logic                             o_tx_data,
    output logic                             o_tx_valid,
    output logic                             o_tx_finish,
    output logic                             o_busy
);

    localparam int AW = addr_width(NUM_WORDS);
`ifdef TX_STREAM_PARITY_EN
    localparam int BPW = DATA_WIDTH + 1;
`else
    localparam int BPW = DATA_WIDTH;
`endif
    localparam int CW = $clog2(DATA_WIDTH + 2);

    logic [BPW-1:0] r_shift, w_word;
    logic [CW-1:0]  r_bit_cnt;
    logic [AW-1:0]  r_addr;
    logic           w_clr, w_load, w_hs, w_last_bit, w_last_word;

`ifdef TX_STREAM_PARITY_EN
    // Parity sits at whichever end of the register is shifted out last.
    assign w_word = LSB_FIRST ? {^i_mem_q, i_mem_q} : {i_mem_q, ^i_mem_q};
`else
    assign w_word = i_mem_q;
`endif

    assign w_hs        = o_tx_valid & i_rx_ready;
    assign w_last_bit  = w_hs & (r_bit_cnt == CW'(BPW - 1));
    assign w_last_word = r_addr == AW'(NUM_WORDS - 1);
    assign o_mem_addr  = o_mem_rd ? r_addr : '0;
    assign o_tx_data   = o_tx_valid & (LSB_FIRST ? r_shift[0] : r_shift[BPW-1]);

    tx_stream_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_last_bit (w_last_bit),
        .i_last_word(w_last_word),
        .o_clr      (w_clr),
        .o_load     (w_load),
        .o_mem_rd   (o_mem_rd),
        .o_tx_valid (o_tx_valid),
        .o_tx_finish(o_tx_finish),
        .o_busy     (o_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_addr    <= '0;
        end else begin
            if (w_load)    r_shift <= w_word;
            else if (w_hs) r_shift <= LSB_FIRST ? r_shift >> 1 : r_shift << 1;
            if (w_load)    r_bit_cnt <= '0;
            else if (w_hs) r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_clr)                           r_addr <= '0;
            else if (w_last_bit && !w_last_word) r_addr <= r_addr + AW'(1);
        end
    end

endmodule

// File: tb/tb_tx_stream.sv
// tb_tx_stream: directed checks of tx_stream in LSB-first (4 words) and MSB-first (2 words) builds.
module tb_tx_stream;

`ifdef TX_STREAM_PARITY_EN
    localparam int          BPW  = 9;
    localparam logic [35:0] EXP0 = 36'b101001010_001111000_111111110_100000001;
    localparam logic [17:0] EXP1 = 18'b101001010_101101000;
`else
    localparam int          BPW  = 8;
    localparam logic [35:0] EXP0 = 36'hA53CFF80;
    localparam logic [17:0] EXP1 = 18'hA5B4;
`endif
    localparam int LEN0 = 1 + 4 * (2 + BPW);
    localparam int LEN1 = 1 + 2 * (2 + BPW);

    logic       clk, rst_n;
    logic       s0, r0, rd0, d0, v0, f0, b0;
    logic [1:0] a0;
    logic [7:0] q0;
    logic       s1, r1, rd1, d1, v1, f1, b1;
    logic [0:0] a1;
    logic [7:0] q1;
    logic [7:0] mem0 [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    logic [7:0] mem1 [2] = '{8'hA5, 8'hB4};

    int          checks = 0, errors = 0;
    logic [35:0] str;
    logic [17:0] str1;
    int          n, nb, fc;

    tx_stream #(.DATA_WIDTH(8), .NUM_WORDS(4), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .i_start(s0), .i_rx_ready(r0), .o_mem_rd(rd0),
        .o_mem_addr(a0), .i_mem_q(q0), .o_tx_data(d0), .o_tx_valid(v0),
        .o_tx_finish(f0), .o_busy(b0)
    );

    tx_stream #(.DATA_WIDTH(8), .NUM_WORDS(2), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .i_start(s1), .i_rx_ready(r1), .o_mem_rd(rd1),
        .o_mem_addr(a1), .i_mem_q(q1), .o_tx_data(d1), .o_tx_valid(v1),
        .o_tx_finish(f1), .o_busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd0) q0 <= mem0[a0];
        if (rd1) q1 <= mem1[a1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame on u0; returns in the tx_finish cycle.
    task automatic run0(input bit toggle, input int mid_start,
                        output logic [35:0] s, output int cyc, output int bits);
        logic hold, hd;
        s = '0; bits = 0; cyc = 1; hold = 1'b0; hd = 1'b0;
        s0 = 1'b1;
        step();
        s0 = 1'b0;
        chk("rd_cycle1", rd0, 1);
        chk("addr_cycle1", a0, 0);
        while (!f0 && cyc < 300) begin
            if (hold) chk("hold_data", d0, hd);
            if (v0 && r0) begin
                s = {s[34:0], d0};
                bits++;
            end
            hold = v0 && !r0;
            hd = d0;
            step();
            cyc++;
            r0 = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            s0 = (cyc == mid_start);
        end
        s0 = 1'b0;
        r0 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; s0 = 1'b0; r0 = 1'b1; s1 = 1'b0; r1 = 1'b1;
        step();
        step();
        chk("rst_data", d0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_finish", f0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_mem_rd", rd0, 0);
        chk("rst_mem_addr", a0, 0);
        rst_n = 1'b1;
        step();

        run0(1'b0, -1, str, n, nb);
        chk("len_frame1", n, LEN0);
        chk("bits_frame1", nb, 4 * BPW);
        chk("stream_frame1", str, EXP0);
        chk("busy_at_finish", b0, 1);
        step();
        chk("busy_after_finish", b0, 0);
        chk("finish_one_cycle", f0, 0);

        run0(1'b1, 5, str, n, nb);
        chk("bits_toggle", nb, 4 * BPW);
        chk("stream_toggle", str, EXP0);
        s0 = 1'b1;
        step();
        s0 = 1'b0;
        chk("done_start_ignored", b0, 0);
        fc = 0;
        repeat (60) begin
            step();
            if (f0) fc++;
        end
        chk("no_extra_finish", fc, 0);

        s0 = 1'b1;
        step();
        s0 = 1'b0;
        repeat (24) step();
        chk("pre_rst_valid", v0, 1);
        chk("pre_rst_data", d0, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_data", d0, 0);
        chk("abort_valid", v0, 0);
        chk("abort_busy", b0, 0);
        chk("abort_finish", f0, 0);
        step();
        rst_n = 1'b1;
        fc = 0;
        repeat (60) begin
            step();
            if (f0) fc++;
        end
        chk("abort_no_finish", fc, 0);
        run0(1'b0, -1, str, n, nb);
        chk("len_after_abort", n, LEN0);
        chk("stream_after_abort", str, EXP0);

        str1 = '0; nb = 0; n = 1;
        s1 = 1'b1;
        step();
        s1 = 1'b0;
        while (!f1 && n < 300) begin
            if (v1) begin
                str1 = {str1[16:0], d1};
                nb++;
            end
            step();
            n++;
        end
        chk("msb_len", n, LEN1);
        chk("msb_bits", nb, 2 * BPW);
        chk("msb_stream", str1, EXP1);
        step();
        chk("msb_busy_after", b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_stream.md
# tx_stream

Parametrised synchronous serial transmitter that streams a frame of NUM_WORDS words, each DATA_WIDTH bits wide, from a synchronous-read word memory onto a single-bit valid/ready link. It generalises the fixed 4×8-bit LSB-first transmitter with configurable word width and frame depth, a selectable bit order, an explicit start trigger, a busy flag and an optional per-word parity bit. It connects directly to the link receiver and to an external memory/ROM with one-cycle read latency.

## Interface
- DATA_WIDTH, 8, bits per word; legal range ≥2.
- NUM_WORDS, 4, words per frame; legal range ≥1.
- LSB_FIRST, 1, 1 = bit 0 of each word first; 0 = bit DATA_WIDTH-1 first.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to send a frame; ignored unless in IDLE.
- rx_ready  in  1  receiver accepts the current bit this cycle.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  AW = max(1,$clog2(NUM_WORDS))  word address.
- mem_q  in  DATA_WIDTH  read data, valid the cycle after mem_rd.
- tx_data  out  1  current serial bit; 0 whenever tx_valid = 0.
- tx_valid  out  1  tx_data is valid.
- tx_finish  out  1  one-cycle pulse after the last bit of the frame.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, LOAD, SEND, DONE.
- IDLE: when start = 1, clear addr to 0 and go to READ.
- READ: mem_rd = 1, mem_addr = addr; go to LOAD.
- LOAD: capture mem_q into the shift register, clear bit_cnt, go to SEND.
- SEND: tx_valid = 1. A bit transfers on each cycle with tx_valid & rx_ready; the register then shifts (right if LSB_FIRST, left otherwise, zero fill) and bit_cnt increments.
- On the last bit of a word: if addr == NUM_WORDS-1, go to DONE; otherwise addr increments and the FSM goes to READ.
- DONE: tx_finish = 1 for one cycle, then IDLE.
- rx_ready low in SEND: tx_data, the shift register and bit_cnt hold; there is no timeout.
- bit_cnt width is $clog2(DATA_WIDTH+2). Bits per word is BPW = DATA_WIDTH, or DATA_WIDTH+1 with parity.
- start asserted in any non-IDLE state, including the DONE cycle, is dropped and not queued.
- Reset mid-frame aborts immediately with no tx_finish. All outputs go to 0, the FSM to IDLE and addr to 0.
- NUM_WORDS = 1: addr stays 0, and the frame is READ, LOAD, SEND, DONE.

## Timing
- Reset values: tx_data = 0, tx_valid = 0, tx_finish = 0, busy = 0, mem_rd = 0, mem_addr = 0.
- start sampled at edge 0: READ in cycle 1, LOAD in cycle 2, first tx_valid in cycle 3.
- Each word costs 2 overhead cycles plus BPW cycles with rx_ready held high.
- Full frame with rx_ready held high: start-to-tx_finish = 1 + NUM_WORDS·(2+BPW) cycles; default (no parity) is 41.
- mem_rd is high for exactly one cycle per word; mem_q is sampled only in LOAD.

## Configuration
- TX_STREAM_PARITY_EN defined: even parity of the word is computed in LOAD and sent as bit BPW-1, after the data bits, under the same handshake. BPW = DATA_WIDTH+1.
- TX_STREAM_PARITY_EN undefined: no parity logic exists, and BPW = DATA_WIDTH.

## Structure
- Package tx_stream_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, READ, LOAD, SEND, DONE};
  - the AW width function.
- Sub-module tx_stream_fsm holds the state register, the next-state logic, and the mem_rd/tx_valid/tx_finish/busy decode.
- The top level holds the shift register, bit_cnt, addr and the parity generator.

## Test plan
- Defaults, memory = {A5, 3C, FF, 01}, rx_ready = 1, start pulse:
  - bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 and so on;
  - tx_finish occurs 41 cycles after start;
  - busy drops the cycle after tx_finish.
- LSB_FIRST = 0, word A5: serial sequence is 1,0,1,0,0,1,0,1 MSB-first; B4 gives 1,0,1,1,0,1,0,0.
- rx_ready toggled 1,0,0,1 during SEND: tx_data holds through the low cycles, and no bit is lost or duplicated.
- start re-pulsed mid-frame and during DONE: ignored; exactly one tx_finish occurs per accepted start.
- rst_n asserted in the third word:
  - all outputs are 0 immediately, and tx_finish never fires;
  - the next start sends word 0 first.
- TX_STREAM_PARITY_EN, DATA_WIDTH = 8, word 07: 9 bits sent, with final parity bit 1; frame length is 45 cycles.
